kernel_stream_ctrl: RTL and testbench

KERNEL_STREAM_CTRL -- requirements
Module: kernel_stream_ctrl

---
 rtl/kernel_stream_ctrl_if.sv | 21 ++
 rtl/kernel_stream_ctrl.sv | 89 ++++++++
 tb/tb_kernel_stream_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_stream_ctrl_if.sv
// kernel_stream_ctrl_if: handshake bundle between the stream source, the kernel and the stream sink.
//   master (controller side): drives src_ready, k_ivalid, k_oready, snk_valid
//   slave  (environment side): drives src_valid, k_iready, k_ovalid, snk_ready
interface kernel_stream_ctrl_if;
    logic src_valid;
    logic src_ready;
    logic k_ivalid;
    logic k_iready;
    logic k_ovalid;
    logic k_oready;
    logic snk_valid;
    logic snk_ready;
    modport master (
        input  src_valid, k_iready, k_ovalid, snk_ready,
        output src_ready, k_ivalid, k_oready, snk_valid
    );
    modport slave (
        output src_valid, k_iready, k_ovalid, snk_ready,
        input  src_ready, k_ivalid, k_oready, snk_valid
    );
endinterface

// File: rtl/kernel_stream_ctrl.sv
// kernel_stream_ctrl: run controller that gates the kernel stream handshakes and counts items.
//   clk, rst (async, active low), start pulse, nitems run length,
//   busy/done status, in_count/out_count item counters,
//   s (master modport) carrying src/kernel/sink handshakes.
//   Optional macro KERNEL_STREAM_CTRL_PERF_EN adds stall_cycles (sink back-pressure cycles).
module kernel_stream_ctrl #(
    parameter int CNTW        = 32,
    parameter int MAXINFLIGHT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNTW-1:0]  nitems,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  in_count,
    output logic [CNTW-1:0]  out_count,
`ifdef KERNEL_STREAM_CTRL_PERF_EN
    output logic [31:0]      stall_cycles,
`endif
    kernel_stream_ctrl_if.master s
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t          r_state, w_next;
    logic [CNTW-1:0] r_nitems, r_in_count, r_out_count;
    logic [CNTW-1:0] w_in_next, w_out_next;
    logic            w_start_ok, w_issue_ok, w_in_xfer, w_out_xfer;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_issue_ok = (r_state == RUN) && (r_in_count < r_nitems) &&
                        ((r_in_count - r_out_count) < CNTW'(MAXINFLIGHT));
    assign w_in_xfer  = s.k_ivalid & s.k_iready;
    assign w_out_xfer = s.snk_valid & s.snk_ready;
    assign w_in_next  = r_in_count + CNTW'(w_in_xfer);
    assign w_out_next = r_out_count + CNTW'(w_out_xfer);
    assign in_count   = r_in_count;
    assign out_count  = r_out_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Transitions look at the post-transfer counts so the state moves on the same edge
    // as the final transfer; coincident final in/out transfers skip DRAIN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (nitems != '0) ? RUN : DONE;
            RUN:     if (w_in_next == r_nitems) w_next = (w_out_next == r_nitems) ? DONE : DRAIN;
            DRAIN:   if (w_out_next == r_nitems) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == RUN) || (r_state == DRAIN);
        done        = (r_state == DONE);
        s.k_ivalid  = s.src_valid & w_issue_ok;
        s.src_ready = s.k_iready & w_issue_ok;
        s.snk_valid = s.k_ovalid & busy;
        s.k_oready  = s.snk_ready & busy;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nitems    <= '0;
            r_in_count  <= '0;
            r_out_count <= '0;
        end else if (w_start_ok) begin
            r_nitems    <= nitems;
            r_in_count  <= '0;
            r_out_count <= '0;
        end else begin
            r_in_count  <= w_in_next;
            r_out_count <= w_out_next;
        end
    end

`ifdef KERNEL_STREAM_CTRL_PERF_EN
    logic [31:0] r_stall;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                                    r_stall <= '0;
        else if (w_start_ok)                                         r_stall <= '0;
        else if (s.snk_valid && !s.snk_ready && r_stall != '1)       r_stall <= r_stall + 32'd1;
    end
    assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_kernel_stream_ctrl.sv
// tb_kernel_stream_ctrl: directed test of kernel_stream_ctrl with a latency-modelled kernel.
module tb_kernel_stream_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, done;
    logic [31:0] nitems, in_count, out_count;
    logic        start2, busy2, done2;
    logic [31:0] nitems2, in_count2, out_count2;
`ifdef KERNEL_STREAM_CTRL_PERF_EN
    logic [31:0] stall_cycles, stall_cycles2;
`endif

    kernel_stream_ctrl_if sif();
    kernel_stream_ctrl_if sif2();

    logic pass, m_ovalid, t_kiready;
    assign sif.k_ovalid = pass ? sif.k_ivalid : m_ovalid;
    assign sif.k_iready = pass ? sif.k_oready : t_kiready;

    kernel_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .nitems(nitems),
        .busy(busy), .done(done), .in_count(in_count), .out_count(out_count),
`ifdef KERNEL_STREAM_CTRL_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .s(sif.master)
    );

    kernel_stream_ctrl #(.MAXINFLIGHT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .nitems(nitems2),
        .busy(busy2), .done(done2), .in_count(in_count2), .out_count(out_count2),
`ifdef KERNEL_STREAM_CTRL_PERF_EN
        .stall_cycles(stall_cycles2),
`endif
        .s(sif2.master)
    );

    int n_chk = 0, n_fail = 0, n_in = 0, n_done = 0, cyc = 0, lat = 3;
    logic saw_kiv;
    int q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic xi, xo;
        @(negedge clk);
        xi = sif.k_ivalid & sif.k_iready;
        xo = sif.snk_valid & sif.snk_ready;
        if (sif.k_ivalid) saw_kiv = 1'b1;
        if (done) n_done++;
        @(posedge clk);
        #1;
        cyc++;
        if (xi) begin
            n_in++;
            if (!pass) q.push_back(cyc + lat);
        end
        if (xo && !pass && q.size() > 0) q.delete(0);
        m_ovalid = (q.size() > 0) && (q[0] <= cyc);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; nitems = '0; pass = 1'b0; m_ovalid = 1'b0; t_kiready = 1'b0;
        sif.src_valid = 1'b0; sif.snk_ready = 1'b0;
        start2 = 1'b0; nitems2 = '0;
        sif2.src_valid = 1'b0; sif2.k_iready = 1'b0; sif2.k_ovalid = 1'b0; sif2.snk_ready = 1'b0;
        saw_kiv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sif.src_valid = 1'b1; sif.snk_ready = 1'b1; t_kiready = 1'b1; m_ovalid = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in", in_count, 0);
        chk("rst_out", out_count, 0);
        chk("rst_kivalid", sif.k_ivalid, 0);
        chk("rst_srcready", sif.src_ready, 0);
        chk("rst_snkvalid", sif.snk_valid, 0);
        chk("rst_koready", sif.k_oready, 0);
        m_ovalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // nitems=4, everything ready, kernel latency 3
        nitems = 32'd4; start = 1'b1; n_in = 0;
        tick();
        start = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_in0", in_count, 0);
        repeat (2) tick();
        start = 1'b1; nitems = 32'd9;
        tick();
        start = 1'b0;
        tick();
        chk("drain_in", in_count, 4);
        chk("drain_out", out_count, 0);
        chk("drain_busy", busy, 1);
        chk("drain_srcready", sif.src_ready, 0);
        chk("drain_kivalid", sif.k_ivalid, 0);
        repeat (3) tick();
        chk("drain_out3", out_count, 3);
        chk("drain_nodone", done, 0);
        start = 1'b1;
        tick();
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_in", in_count, 4);
        chk("fin_out", out_count, 4);
        tick();
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_in_hold", in_count, 4);
        chk("post_out_hold", out_count, 4);
        chk("in_xfers", n_in, 4);
        tick();
        chk("start_in_done_ignored", busy, 0);

        // nitems=0 goes straight to DONE
        saw_kiv = 1'b0; nitems = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_in_clr", in_count, 0);
        chk("zero_out_clr", out_count, 0);
        tick();
        chk("zero_done_end", done, 0);
        chk("zero_no_kivalid", saw_kiv, 0);

        // pass-through kernel: final input and output coincide
        pass = 1'b1; nitems = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("coin_in2", in_count, 2);
        chk("coin_out2", out_count, 2);
        chk("coin_busy", busy, 1);
        tick();
        chk("coin_done", done, 1);
        chk("coin_busy_off", busy, 0);
        chk("coin_in", in_count, 3);
        chk("coin_out", out_count, 3);
        tick();
        pass = 1'b0;

        // MAXINFLIGHT=2 with sink stalled
        nitems2 = 32'd5; start2 = 1'b1;
        sif2.src_valid = 1'b1; sif2.k_iready = 1'b1; sif2.k_ovalid = 1'b1; sif2.snk_ready = 1'b0;
        tick();
        start2 = 1'b0;
        repeat (4) tick();
        chk("mif_in", in_count2, 2);
        chk("mif_out", out_count2, 0);
        chk("mif_srcready", sif2.src_ready, 0);
        chk("mif_kivalid", sif2.k_ivalid, 0);
        chk("mif_snkvalid", sif2.snk_valid, 1);
        sif2.snk_ready = 1'b1;
        #1;
        chk("mif_srcready_pre", sif2.src_ready, 0);
        chk("mif_koready", sif2.k_oready, 1);
        tick();
        chk("mif_out1", out_count2, 1);
        chk("mif_in_hold", in_count2, 2);
        chk("mif_srcready_open", sif2.src_ready, 1);
        sif2.snk_ready = 1'b0; sif2.k_ovalid = 1'b0; sif2.src_valid = 1'b0;

        // reset mid-run at in_count=5
        nitems = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("abort_in5", in_count, 5);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in", in_count, 0);
        chk("abort_out", out_count, 0);
        chk("abort_kivalid", sif.k_ivalid, 0);
        chk("abort_srcready", sif.src_ready, 0);
        chk("abort_snkvalid", sif.snk_valid, 0);
        chk("abort_koready", sif.k_oready, 0);
        chk("abort_in2", in_count2, 0);
        n_done = 0;
        repeat (2) tick();
        rst = 1'b1;
        q.delete();
        m_ovalid = 1'b0;
        tick();
        chk("abort_no_done", n_done, 0);
        nitems = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        repeat (6) tick();
        chk("restart_done", done, 1);
        chk("restart_in", in_count, 2);
        chk("restart_out", out_count, 2);
        tick();

`ifdef KERNEL_STREAM_CTRL_PERF_EN
        // sink stalled for 7 busy cycles
        nitems = 32'd1; sif.snk_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("perf_clear", stall_cycles, 0);
        repeat (11) tick();
        chk("perf_stall7", stall_cycles, 7);
        sif.snk_ready = 1'b1;
        tick();
        chk("perf_done", done, 1);
        chk("perf_final", stall_cycles, 7);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
